// File: rtl/i2c_slave_regs.sv
// I2C slave with an 8-bit register file, fully synchronous to CLK.
// SCL/SDA are synchronised and glitch-filtered. The device takes an index
// byte, then writes or reads registers with auto-increment and wrap.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h55,
    parameter int         NUM_REGS = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  SCL,
    input  logic                  SDA,
    output logic                  SDAout,
    output logic [8*NUM_REGS-1:0] REGS_OUT,
    output logic                  WR_STROBE,
    output logic [7:0]            WR_INDEX,
    output logic                  BUSY
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);
    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(NUM_REGS - 1);
    localparam logic [8:0]       NREGS9  = 9'(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, IDX, IDX_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // Input path: bit 1 carries SCL, bit 0 carries SDA
    logic [1:0]       sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [CNT_W-1:0] fcnt_q [2];

    // Protocol state
    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             sda_out_q, sda_out_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;      // second half of an ACK slot
    logic             rw_q, rw_d;
    logic             wr_en;
    logic             wr_strobe_q;
    logic [7:0]       wr_index_q, wr_index_d;
    logic [7:0]       regs_q [NUM_REGS];

    logic             scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]       byte_in;
    logic [IDX_W-1:0] ptr_inc;

    // Synchroniser plus per-line filter: the filtered value follows only after
    // FILT_LEN consecutive samples that disagree with it
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            fcnt_q[0]   <= '0;
            fcnt_q[1]   <= '0;
        end else begin
            sync1_q     <= {SCL, SDA};
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CNT_MAX) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign scl_f    = filt_q[1];
    assign sda_f    = filt_q[0];
    assign scl_rise = scl_f & ~filt_prev_q[1];
    assign scl_fall = ~scl_f & filt_prev_q[1];
    assign start_c  = scl_f & filt_prev_q[1] & filt_prev_q[0] & ~sda_f;
    assign stop_c   = scl_f & filt_prev_q[1] & ~filt_prev_q[0] & sda_f;
    assign byte_in  = {shift_q[6:0], sda_f};
    assign ptr_inc  = (ptr_q == PTR_MAX) ? '0 : ptr_q + IDX_W'(1);

    // Protocol FSM: START/STOP override everything, otherwise bits move on SCL edges
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_out_d  = sda_out_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        rw_d       = rw_q;
        wr_en      = 1'b0;
        wr_index_d = wr_index_q;
        if (stop_c) begin
            state_d   = IDLE;
            ptr_d     = '0;
            busy_d    = 1'b0;
            sda_out_d = 1'b1;
            ack_d     = 1'b0;
        end else if (start_c) begin
            state_d   = ADDR;
            bitcnt_d  = 3'd0;
            sda_out_d = 1'b1;
            ack_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'd0) begin
                                rw_d    = byte_in[0];
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_out_d = 1'b0;
                            busy_d    = 1'b1;
                            ack_d     = 1'b1;
                        end else begin
                            ack_d    = 1'b0;
                            bitcnt_d = 3'd0;
                            if (rw_q) begin
                                shift_d   = regs_q[ptr_q];
                                sda_out_d = regs_q[ptr_q][7];
                                state_d   = RDATA;
                            end else begin
                                sda_out_d = 1'b1;
                                state_d   = IDX;
                            end
                        end
                    end
                end
                IDX: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            if ({1'b0, byte_in} >= NREGS9) begin
                                state_d = IDLE;
                            end else begin
                                ptr_d   = byte_in[IDX_W-1:0];
                                state_d = IDX_ACK;
                            end
                        end
                    end
                end
                IDX_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_out_d = 1'b0;
                            ack_d     = 1'b1;
                        end else begin
                            sda_out_d = 1'b1;
                            ack_d     = 1'b0;
                            bitcnt_d  = 3'd0;
                            state_d   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            wr_en      = 1'b1;
                            wr_index_d = 8'(ptr_q);
                            ptr_d      = ptr_inc;
                            state_d    = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            ack_d   = 1'b0;
                            state_d = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_out_d = shift_q[6];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall && !ack_q) begin
                        sda_out_d = 1'b1;
                    end else if (scl_rise) begin
                        if (sda_f) state_d = IDLE;
                        else       ack_d   = 1'b1;
                    end else if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        ptr_d     = ptr_inc;
                        shift_d   = regs_q[ptr_inc];
                        sda_out_d = regs_q[ptr_inc][7];
                        bitcnt_d  = 3'd0;
                        state_d   = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Protocol state registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            rw_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_en;
            wr_index_q  <= wr_index_d;
        end
    end

    // Register file, written with the byte completed on the 8th data bit
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
        end else if (wr_en) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign REGS_OUT[8*g +: 8] = regs_q[g];
    end

    assign SDAout    = sda_out_q;
    assign BUSY      = busy_q;
    assign WR_STROBE = wr_strobe_q;
    assign WR_INDEX  = wr_index_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master on a wired-AND SDA,
// a table of byte-level bus operations with expected results, and a few
// hand-written sequences for glitches, aborts and mid-transfer reset.
module tb_i2c_slave_regs;

    localparam int NREGS = 8;

    logic               CLK = 1'b0;
    logic               RSTN = 1'b0;
    logic               scl_m = 1'b1;
    logic               sda_m = 1'b1;
    logic               sda_bus;
    logic               SDAout, WR_STROBE, BUSY;
    logic [7:0]         WR_INDEX;
    logic [8*NREGS-1:0] REGS_OUT;

    assign sda_bus = sda_m & SDAout;

    i2c_slave_regs #(.DEV_ADDR(7'h55), .NUM_REGS(NREGS), .FILT_LEN(3)) dut (
        .CLK(CLK), .RSTN(RSTN), .SCL(scl_m), .SDA(sda_bus), .SDAout(SDAout),
        .REGS_OUT(REGS_OUT), .WR_STROBE(WR_STROBE), .WR_INDEX(WR_INDEX), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Strobe log and SDA-low counter, sampled on the falling clock edge
    logic [7:0] stb_log [256];
    int stb_n = 0;
    int low_cnt = 0;
    always @(negedge CLK) begin
        if (RSTN) begin
            if (WR_STROBE) begin
                stb_log[stb_n[7:0]] = WR_INDEX;
                stb_n++;
            end
            if (SDAout == 1'b0) low_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One SCL period: data set mid-low, sampled mid-high
    task automatic clk_bit(input logic b, input logic glitch, output logic s);
        tick(5); sda_m = b; tick(5); scl_m = 1'b1;
        if (glitch) begin
            tick(2); scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(2);
        end else begin
            tick(5);
        end
        s = sda_bus; tick(5); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1;
        end
        tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b1; tick(10); sda_m = 1'b1; tick(10);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], 1'b0, s);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clk_bit(mack, 1'b0, s);
    endtask

    typedef enum int {
        OP_START, OP_STOP, OP_WB, OP_RB, OP_REG, OP_BSY, OP_SDA,
        OP_STB, OP_NOSTB, OP_LOWCLR, OP_LOW0
    } op_t;
    typedef struct {
        op_t        op;
        logic [7:0] d;   // byte to send / master ACK bit / register index
        logic [7:0] e;   // expected ACK bit / read byte / register value / index
    } vec_t;
    vec_t vt[$];

    function automatic void add(op_t op, logic [7:0] d, logic [7:0] e);
        vec_t v;
        v.op = op; v.d = d; v.e = e;
        vt.push_back(v);
    endfunction

    logic       a, s;
    logic [7:0] rb, gd;
    int         stb_rd = 0;
    int         low_base = 0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Wrap: index 7, two bytes land in reg7 then reg0
        add(OP_START, 0, 0); add(OP_WB, 8'hAA, 0); add(OP_BSY, 0, 1);
        add(OP_WB, 8'h07, 0); add(OP_WB, 8'hA1, 0); add(OP_WB, 8'hB2, 0); add(OP_STOP, 0, 0);
        add(OP_BSY, 0, 0); add(OP_REG, 7, 8'hA1); add(OP_REG, 0, 8'hB2);
        add(OP_STB, 0, 7); add(OP_STB, 0, 0); add(OP_NOSTB, 0, 0);
        // Plain write at index 2
        add(OP_START, 0, 0); add(OP_WB, 8'hAA, 0); add(OP_WB, 8'h02, 0);
        add(OP_WB, 8'h12, 0); add(OP_WB, 8'h34, 0); add(OP_BSY, 0, 1); add(OP_STOP, 0, 0);
        add(OP_BSY, 0, 0); add(OP_REG, 2, 8'h12); add(OP_REG, 3, 8'h34);
        add(OP_STB, 0, 2); add(OP_STB, 0, 3); add(OP_NOSTB, 0, 0);
        // Pointer cleared by STOP: a read without index returns reg0
        add(OP_START, 0, 0); add(OP_WB, 8'hAB, 0); add(OP_RB, 1, 8'hB2); add(OP_SDA, 0, 1); add(OP_STOP, 0, 0);
        // Index out of range: NACK, then the slave ignores the rest
        add(OP_START, 0, 0); add(OP_WB, 8'hAA, 0); add(OP_WB, 8'h08, 1); add(OP_WB, 8'h55, 1);
        add(OP_STOP, 0, 0); add(OP_NOSTB, 0, 0); add(OP_REG, 0, 8'hB2);
        // Read with repeated START
        add(OP_START, 0, 0); add(OP_WB, 8'hAA, 0); add(OP_WB, 8'h02, 0); add(OP_START, 0, 0);
        add(OP_WB, 8'hAB, 0); add(OP_RB, 0, 8'h12); add(OP_RB, 1, 8'h34); add(OP_SDA, 0, 1);
        add(OP_STOP, 0, 0); add(OP_BSY, 0, 0); add(OP_NOSTB, 0, 0);
        // Read wrapping from reg7 to reg0
        add(OP_START, 0, 0); add(OP_WB, 8'hAA, 0); add(OP_WB, 8'h07, 0); add(OP_START, 0, 0);
        add(OP_WB, 8'hAB, 0); add(OP_RB, 0, 8'hA1); add(OP_RB, 1, 8'hB2); add(OP_STOP, 0, 0);
        // Address mismatch and general call: bus never pulled low
        add(OP_LOWCLR, 0, 0); add(OP_START, 0, 0); add(OP_WB, 8'hA0, 1); add(OP_BSY, 0, 0);
        add(OP_WB, 8'h02, 1); add(OP_WB, 8'h55, 1); add(OP_STOP, 0, 0);
        add(OP_START, 0, 0); add(OP_WB, 8'h00, 1); add(OP_STOP, 0, 0);
        add(OP_LOW0, 0, 0); add(OP_NOSTB, 0, 0);

        // Reset with the bus toggling
        RSTN = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            scl_m = c[0]; sda_m = c[1];
        end
        check("reset SDAout", SDAout, 1);
        check("reset BUSY", BUSY, 0);
        check("reset WR_STROBE", WR_STROBE, 0);
        check("reset REGS_OUT", REGS_OUT, 0);
        check("reset WR_INDEX", WR_INDEX, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(10); RSTN = 1'b1; tick(10);

        foreach (vt[i]) begin
            case (vt[i].op)
                OP_START:  i2c_start();
                OP_STOP:   i2c_stop();
                OP_WB: begin
                    wr_byte(vt[i].d, a);
                    check($sformatf("v%0d ack after %02h", i, vt[i].d), a, vt[i].e[0]);
                end
                OP_RB: begin
                    rd_byte(vt[i].d[0], rb);
                    check($sformatf("v%0d read byte", i), rb, vt[i].e);
                end
                OP_REG:    check($sformatf("v%0d reg%0d", i, vt[i].d), REGS_OUT[8*vt[i].d +: 8], vt[i].e);
                OP_BSY:    check($sformatf("v%0d BUSY", i), BUSY, vt[i].e[0]);
                OP_SDA:    check($sformatf("v%0d SDAout", i), SDAout, vt[i].e[0]);
                OP_STB: begin
                    if (stb_n > stb_rd) begin
                        check($sformatf("v%0d WR_INDEX", i), stb_log[stb_rd[7:0]], vt[i].e);
                        stb_rd++;
                    end else begin
                        check($sformatf("v%0d strobe count", i), stb_n, stb_rd + 1);
                    end
                end
                OP_NOSTB: begin
                    check($sformatf("v%0d extra strobes", i), stb_n, stb_rd);
                    stb_rd = stb_n;
                end
                OP_LOWCLR: low_base = low_cnt;
                OP_LOW0:   check($sformatf("v%0d SDA low cycles", i), low_cnt - low_base, 0);
                default: ;
            endcase
        end

        // 1-CLK SCL glitch inside a data bit must not add a bit
        i2c_start();
        wr_byte(8'hAA, a); check("glitch addr ack", a, 0);
        wr_byte(8'h03, a); check("glitch idx ack", a, 0);
        gd = 8'h5C;
        for (int i = 7; i >= 0; i--) clk_bit(gd[i], (i == 4), s);
        clk_bit(1'b1, 1'b0, a); check("glitch data ack", a, 0);
        i2c_stop();
        check("glitch strobe count", stb_n - stb_rd, 1);
        check("glitch WR_INDEX", stb_log[stb_rd[7:0]], 3);
        stb_rd = stb_n;
        check("glitch reg3", REGS_OUT[31:24], 8'h5C);

        // STOP after 4 data bits: no write, pointer back to 0
        i2c_start();
        wr_byte(8'hAA, a); check("abort addr ack", a, 0);
        wr_byte(8'h05, a); check("abort idx ack", a, 0);
        clk_bit(1'b1, 1'b0, s); clk_bit(1'b0, 1'b0, s); clk_bit(1'b1, 1'b0, s); clk_bit(1'b1, 1'b0, s);
        i2c_stop();
        check("abort strobes", stb_n, stb_rd);
        check("abort reg5", REGS_OUT[47:40], 8'h00);
        check("abort BUSY", BUSY, 0);
        i2c_start();
        wr_byte(8'hAB, a); check("abort read addr ack", a, 0);
        rd_byte(1'b1, rb); check("abort read reg0", rb, 8'hB2);
        i2c_stop();

        // Reset in the middle of a data byte
        i2c_start();
        wr_byte(8'hAA, a); check("midrst addr ack", a, 0);
        wr_byte(8'h01, a); check("midrst idx ack", a, 0);
        clk_bit(1'b1, 1'b0, s); clk_bit(1'b0, 1'b0, s); clk_bit(1'b1, 1'b0, s);
        RSTN = 1'b0; tick(2);
        check("midrst REGS_OUT", REGS_OUT, 0);
        check("midrst SDAout", SDAout, 1);
        check("midrst BUSY", BUSY, 0);
        check("midrst WR_INDEX", WR_INDEX, 0);
        RSTN = 1'b1; tick(2);
        i2c_stop(); tick(10);
        check("midrst strobes", stb_n, stb_rd);
        i2c_start();
        wr_byte(8'hAA, a); check("post addr ack", a, 0);
        wr_byte(8'h01, a); check("post idx ack", a, 0);
        wr_byte(8'h77, a); check("post data ack", a, 0);
        i2c_stop();
        check("post reg1", REGS_OUT[15:8], 8'h77);
        check("post strobe count", stb_n - stb_rd, 1);
        check("post WR_INDEX", stb_log[stb_rd[7:0]], 1);
        stb_rd = stb_n;
        i2c_start();
        wr_byte(8'hAB, a); check("post read addr ack", a, 0);
        rd_byte(1'b1, rb); check("post read reg0", rb, 8'h00);
        i2c_stop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
